// File: rtl/data_receiver_if.sv
// Link-side bundle for data_receiver: the three serial link wires from the
// sender plus the recovered word and its status strobes.
//
// Handshake: valid is a one-cycle strobe with no ready. out_data is stable
// from the cycle valid is high until the next valid, and the consumer must
// capture it before then. frame_error is a one-cycle strobe that never
// coincides with valid. busy is a level, high while a frame is in progress.
interface data_receiver_if #(
  parameter int WIDTH = 64
);
  logic             transmission;
  logic             clock;
  logic             data;
  logic [WIDTH-1:0] out_data;
  logic             valid;
  logic             frame_error;
  logic             busy;

  // Sender / testbench side: drives the link and observes the results.
  modport master (
    output transmission, clock, data,
    input  out_data, valid, frame_error, busy
  );

  // Receiver side.
  modport slave (
    input  transmission, clock, data,
    output out_data, valid, frame_error, busy
  );
endinterface

// File: rtl/data_receiver.sv
// Serial frame receiver. It oversamples the three-wire link (frame line,
// serial clock, data) in the clk domain, shifts in one bit per serial-clock
// rise while the frame is open, and checks the bit count when the frame
// closes. A complete word is published on out_data with a valid strobe, and a
// wrong-length frame gives a frame_error strobe.
module data_receiver #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_receiver_if.slave link,
  output logic [1:0]     dbg_state
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state;

  // Synchronizer chains. All three are the same length so the link lines
  // stay mutually aligned after crossing into the clk domain.
  logic [SYNC_STAGES-1:0] tx_sync;
  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] dt_sync;
  logic [SYNC_STAGES-1:0] fill;

  logic tx_s;
  logic ck_s;
  logic dt_s;
  logic filled;

  // Previous synchronized values and registered edge strobes.
  logic tx_prev;
  logic ck_prev;
  logic armed;
  logic rise_q;
  logic fall_q;
  logic bit_q;
  logic data_q;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  assign tx_s   = tx_sync[SYNC_STAGES-1];
  assign ck_s   = ck_sync[SYNC_STAGES-1];
  assign dt_s   = dt_sync[SYNC_STAGES-1];
  assign filled = fill[SYNC_STAGES-1];

  // Move the link lines into the clk domain. fill marks when the chains hold
  // real line samples rather than their reset zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sync <= '0;
      ck_sync <= '0;
      dt_sync <= '0;
      fill    <= '0;
    end else begin
      tx_sync <= {tx_sync[SYNC_STAGES-2:0], link.transmission};
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], link.clock};
      dt_sync <= {dt_sync[SYNC_STAGES-2:0], link.data};
      fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge detection, registered so the FSM sees clean one-cycle strobes. The
  // data bit gets a matching delay so it lines up with the bit strobe. A
  // frame rise is only honoured after the real frame line has been seen low,
  // so a line already high when reset releases does not open a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_prev <= 1'b0;
      ck_prev <= 1'b0;
      armed   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      bit_q   <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      tx_prev <= tx_s;
      ck_prev <= ck_s;
      armed   <= armed | (filled & ~tx_s);
      rise_q  <= tx_s & ~tx_prev & armed;
      fall_q  <= ~tx_s & tx_prev;
      bit_q   <= ck_s & ~ck_prev;
      data_q  <= dt_s;
    end
  end

  // Frame FSM with shift register, bit counter and registered result strobes.
  // Every frame fall returns to IDLE, so a misbehaving link cannot wedge it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shreg            <= '0;
      cnt              <= '0;
      link.out_data    <= '0;
      link.valid       <= 1'b0;
      link.frame_error <= 1'b0;
    end else begin
      link.valid       <= 1'b0;
      link.frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q) begin
            state <= SHIFT;
            if (bit_q) begin
              shreg <= {{(WIDTH-1){1'b0}}, data_q};
              cnt   <= CW'(1);
            end else begin
              shreg <= '0;
              cnt   <= '0;
            end
          end
        end
        SHIFT: begin
          if (fall_q) begin
            state <= IDLE;
            if (cnt == FULL) begin
              link.out_data <= shreg;
              link.valid    <= 1'b1;
            end else begin
              link.frame_error <= 1'b1;
            end
          end else if (bit_q) begin
            if (cnt == FULL) begin
              state <= DISCARD;
            end else begin
              shreg <= {shreg[WIDTH-2:0], data_q};
              cnt   <= cnt + CW'(1);
            end
          end
        end
        DISCARD: begin
          if (fall_q) begin
            state            <= IDLE;
            link.frame_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign link.busy = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: good, short and overrun frames, stray
// serial clocks, reset mid-frame and back-to-back frames.
module tb_data_receiver;

  localparam int WIDTH = 64;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  data_receiver_if #(.WIDTH(WIDTH)) link ();

  data_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link),
    .dbg_state (dbg_state)
  );

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;

  logic [WIDTH-1:0] exp_q[$];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (link.valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("valid_word", link.out_data, exp_q.pop_front());
      end
      if (link.frame_error) err_cnt++;
      if (link.valid && link.frame_error) check("valid_and_error", 64'd1, 64'd0);
    end
  end

  // Raise the frame line; busy must appear exactly 4 cycles later.
  task automatic frame_open();
    link.transmission = 1'b1;
    cycles(3);
    check("busy_early", 64'(link.busy), 64'd0);
    cycles(1);
    check("busy_latency", 64'(link.busy), 64'd1);
  endtask

  // Send nbits MSB first; bits beyond the word width are sent as 0.
  task automatic send_bits(input logic [WIDTH-1:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = nbits - 1 - i;
      link.data  = (idx < WIDTH) ? word[idx] : 1'b0;
      link.clock = 1'b0;
      cycles(4);
      link.clock = 1'b1;
      cycles(4);
    end
  endtask

  // Drop the frame line and check the result strobes and their latency.
  task automatic frame_close(input logic exp_valid, input logic exp_err,
                             input logic [WIDTH-1:0] exp_word);
    link.clock = 1'b0;
    cycles(4);
    link.transmission = 1'b0;
    cycles(3);
    check("pulse_early", 64'({link.valid, link.frame_error}), 64'd0);
    cycles(1);
    check("pulse_latency", 64'({link.valid, link.frame_error}), 64'({exp_valid, exp_err}));
    check("out_data_at_close", link.out_data, exp_word);
    check("busy_after_close", 64'(link.busy), 64'd0);
    cycles(1);
    check("pulse_one_cycle", 64'({link.valid, link.frame_error}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    link.transmission = 1'b0;
    link.clock = 1'b0;
    link.data = 1'b0;
    cycles(3);
    check("rst_out_data", link.out_data, 64'd0);
    check("rst_valid", 64'(link.valid), 64'd0);
    check("rst_frame_error", 64'(link.frame_error), 64'd0);
    check("rst_busy", 64'(link.busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    cycles(5);

    // Good frame
    exp_q.push_back(64'hDEADBEEF01234567);
    frame_open();
    send_bits(64'hDEADBEEF01234567, 64);
    check("busy_in_frame", 64'(link.busy), 64'd1);
    frame_close(1'b1, 1'b0, 64'hDEADBEEF01234567);
    cycles(5);

    // Short frame (63 bits)
    frame_open();
    send_bits(64'h0123456789ABCDEF, 63);
    frame_close(1'b0, 1'b1, 64'hDEADBEEF01234567);
    cycles(5);

    // Overrun (65 bits)
    frame_open();
    send_bits(64'hFEDCBA9876543210, 65);
    check("overrun_discard", 64'(dbg_state), 64'd2);
    frame_close(1'b0, 1'b1, 64'hDEADBEEF01234567);
    cycles(5);
    check("count_after_errors_valid", 64'(valid_cnt), 64'd1);
    check("count_after_errors_err", 64'(err_cnt), 64'd2);

    // Stray serial clocks with the frame line low
    for (int i = 0; i < 10; i++) begin
      link.clock = 1'b1;
      cycles(4);
      link.clock = 1'b0;
      cycles(4);
    end
    check("stray_busy", 64'(link.busy), 64'd0);
    check("stray_valid_cnt", 64'(valid_cnt), 64'd1);
    check("stray_err_cnt", 64'(err_cnt), 64'd2);
    exp_q.push_back(64'h0000000000000001);
    frame_open();
    send_bits(64'h0000000000000001, 64);
    frame_close(1'b1, 1'b0, 64'h0000000000000001);
    cycles(5);

    // Reset mid-frame after 30 bits
    frame_open();
    send_bits(64'h123456789ABCDEF0, 30);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(link.busy), 64'd0);
    check("midrst_out_data", link.out_data, 64'd0);
    link.transmission = 1'b0;
    link.clock = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(6);
    check("midrst_no_valid", 64'(valid_cnt), 64'd2);
    check("midrst_no_err", 64'(err_cnt), 64'd2);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    frame_open();
    send_bits(64'hFFFFFFFFFFFFFFFF, 64);
    frame_close(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    cycles(5);

    // Back-to-back frames with the minimum 3-cycle gap
    exp_q.push_back(64'hAAAAAAAAAAAAAAAA);
    exp_q.push_back(64'h5555555555555555);
    frame_open();
    send_bits(64'hAAAAAAAAAAAAAAAA, 64);
    link.clock = 1'b0;
    cycles(4);
    link.transmission = 1'b0;
    cycles(3);
    frame_open();
    check("b2b_first_valid", 64'(valid_cnt), 64'd4);
    check("b2b_first_word", link.out_data, 64'hAAAAAAAAAAAAAAAA);
    send_bits(64'h5555555555555555, 64);
    frame_close(1'b1, 1'b0, 64'h5555555555555555);
    cycles(5);

    check("final_valid_cnt", 64'(valid_cnt), 64'd5);
    check("final_err_cnt", 64'(err_cnt), 64'd2);
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_receiver.md
# data_receiver

Receiving end of the three-wire serial link driven by `data_transmitter` (`transmission`, `clock`, `data`). It oversamples the link in the local `clk` domain and shifts in one bit per serial-clock rising edge while the frame line is high. It checks the bit count when the frame closes, then presents the complete word with a one-cycle valid strobe. It sits on a second board or in loopback tests, feeding the recovered 64-bit sensor timestamp to downstream logic.

## Interface
- `WIDTH`, 64: payload bits per frame.
- `SYNC_STAGES`, 2: synchronizer flops on each link input (≥2).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `transmission` input 1: frame line, asynchronous to `clk`; high for the whole frame.
- `clock` input 1: serial clock, asynchronous to `clk`.
- `data` input 1: serial data, MSB first, valid at `clock` rising edge.
- `out_data` output WIDTH: last correctly received word.
- `valid` output 1: one-cycle pulse when `out_data` has just been updated.
- `frame_error` output 1: one-cycle pulse when a frame closed with a bit count other than WIDTH.
- `busy` output 1: high while a frame is in progress.

## Operation
- **Synchronization.** `transmission`, `clock` and `data` each pass through an identical SYNC_STAGES-flop chain, so the three remain mutually aligned.
- **Edge detection.** One further register per line holds the previous synchronized value.
  - Frame rise: synchronized `transmission` = 1 and previous = 0.
  - Frame fall: synchronized `transmission` = 0 and previous = 1.
  - Bit edge: synchronized `clock` = 1 and previous = 0.
- **Shift register.** WIDTH bits wide; on an accepted bit edge, shift left and insert synchronized `data` at bit 0.
- **Bit counter.** Width $clog2(WIDTH+1); saturates at WIDTH.
- **FSM states: IDLE, SHIFT, DISCARD.**
  - IDLE → SHIFT on frame rise. The counter and shift register clear. A bit edge in the same cycle is accepted as bit 1.
  - SHIFT, bit edge with count < WIDTH: shift, count+1.
  - SHIFT, bit edge with count = WIDTH: → DISCARD (overrun).
  - SHIFT, frame fall:
    - If count = WIDTH, load `out_data` from the shift register and pulse `valid`.
    - Otherwise pulse `frame_error` and leave `out_data` unchanged.
    - Either way, → IDLE. A bit edge in the same cycle is ignored.
  - DISCARD: ignore bit edges; on frame fall, pulse `frame_error` and → IDLE.
- Bit edges in IDLE are ignored.
- If `transmission` is already high when reset releases, the block does not start a frame. It waits for a low followed by a fresh rise.
- `busy` = (state != IDLE).
- `valid` and `frame_error` never assert in the same cycle.

## Timing
- **Reset values:** state IDLE, `out_data` = 0, `valid` = 0, `frame_error` = 0, `busy` = 0. All synchronizer and edge-detect flops reset to 0.
- Reset asserted mid-frame aborts the frame with no `valid` or `frame_error` pulse. `out_data` returns to 0.
- **Latency, input to registered output:** SYNC_STAGES + 2 `clk` cycles.
  - From the `transmission` fall to the `valid`/`frame_error` pulse.
  - From the `transmission` rise to `busy` = 1.
- **Link requirements** (the receiver's contract with the sender):
  - Serial clock high time and low time each ≥ SYNC_STAGES + 1 `clk` cycles.
  - `data` stable from SYNC_STAGES + 1 cycles before to 1 cycle after each `clock` rise.
  - `transmission` low gap between frames ≥ SYNC_STAGES + 1 cycles.
- Violations of the link requirements may produce wrong data or `frame_error`, but must never hang the FSM. Every frame fall returns the FSM to IDLE.
- `out_data` holds stable between `valid` pulses. There is no back-pressure: a consumer must capture `out_data` before the next `valid`.

## Test plan
- **Good frame.** Frame of 64 bits 0xDEADBEEF01234567, serial half-period 4 `clk` → `busy` high during the frame. One `valid` pulse SYNC_STAGES+2 cycles after the `transmission` fall, `out_data` = 0xDEADBEEF01234567, `frame_error` = 0.
- **Short frame.** Good frame, then a 63-bit frame → one `frame_error` pulse, no `valid`, `out_data` still 0xDEADBEEF01234567.
- **Overrun.** 65-bit frame → state passes through DISCARD, one `frame_error` pulse at the frame fall, no `valid`.
- **Edges outside a frame.** 10 `clock` pulses with `transmission` low, then a good frame of 0x0000000000000001 → no pulses during the stray edges, then `valid` with `out_data` = 1.
- **Reset mid-frame.** Assert `rst` after 30 bits → `busy` = 0 and `out_data` = 0 immediately, no pulse. A subsequent full frame of 0xFFFFFFFFFFFFFFFF is received correctly.
- **Back-to-back frames.** Two frames, 0xAAAAAAAAAAAAAAAA then 0x5555555555555555, separated by the minimum SYNC_STAGES+1 gap → two `valid` pulses with the correct words in order.
